mem_stage: RTL

- Pipeline MEM stage, directly downstream of the execute stage; consumes the registered ex_to_mem_s bundle.
- Runs word loads and stores against a data-memory port with a req/gnt/rvalid handshake.
- Asserts a stall while an access is outstanding.
- Registers the result bundle for write-back and provides the MEM-stage bypass value.

---
 rtl/mem_stage.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Pipeline MEM stage: word loads/stores over a req/gnt/rvalid data-memory port, stall generation,
// write-back result register and MEM bypass. Optional MEM_MISALIGN_CHECK_EN drops misaligned accesses.
module mem_stage #(
  parameter int unsigned BUS_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  // Packed {alu_result[31:0], write_data[31:0], mem_write, reg_write, rd[4:0], mem_read}
  input  logic [71:0] ex_to_mem,
  output logic        stall_mem,
  output logic [31:0] bp_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] wb_result,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        bus_err,
  output logic        misalign
);

  typedef enum logic [1:0] {StIdle, StReq, StWaitResp} state_e;

  logic [31:0] alu_result, write_data;
  logic        mem_write, reg_write, mem_read;
  logic [4:0]  rd;
  logic        is_mem, is_load, misaligned, timeout;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req, abort, drop_mis;
  logic [31:0] wb_result_q, wb_result_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_reg_write_q, wb_reg_write_d;
  logic        bus_err_q, bus_err_d;

  assign alu_result = ex_to_mem[71:40];
  assign write_data = ex_to_mem[39:8];
  assign mem_write  = ex_to_mem[7];
  assign reg_write  = ex_to_mem[6];
  assign rd         = ex_to_mem[5:1];
  assign mem_read   = ex_to_mem[0];

  assign is_mem  = mem_read | mem_write;
  assign is_load = mem_read & ~mem_write;
  assign timeout = (cnt_q == 8'(BUS_TIMEOUT - 1));

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned = is_mem & (alu_result[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign bp_mem     = alu_result;
  assign dmem_addr  = alu_result;
  assign dmem_wdata = write_data;
  assign dmem_we    = mem_write;
  // Reset must silence the request even though IDLE would otherwise decode a held access.
  assign dmem_req   = req & rst_n;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req       = 1'b0;
    stall_mem = 1'b0;
    abort     = 1'b0;
    drop_mis  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (is_mem) begin
          if (misaligned) begin
            drop_mis = 1'b1;
          end else begin
            req   = 1'b1;
            cnt_d = '0;
            if (!dmem_gnt) begin
              stall_mem = 1'b1;
              state_d   = StReq;
            end else if (is_load) begin
              stall_mem = 1'b1;
              state_d   = StWaitResp;
            end
          end
        end
      end
      StReq: begin
        cnt_d = cnt_q + 8'd1;
        if (dmem_gnt) begin
          req = 1'b1;
          if (is_load) begin
            stall_mem = 1'b1;
            cnt_d     = '0;
            state_d   = StWaitResp;
          end else begin
            state_d = StIdle;
          end
        end else if (timeout) begin
          abort   = 1'b1;
          state_d = StIdle;
        end else begin
          req       = 1'b1;
          stall_mem = 1'b1;
        end
      end
      StWaitResp: begin
        cnt_d = cnt_q + 8'd1;
        if (dmem_rvalid) begin
          state_d = StIdle;
        end else if (timeout) begin
          abort   = 1'b1;
          state_d = StIdle;
        end else begin
          stall_mem = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Stall edges insert a bubble into WB; result and destination hold.
  always_comb begin
    wb_result_d    = wb_result_q;
    wb_rd_d        = wb_rd_q;
    wb_reg_write_d = 1'b0;
    bus_err_d      = abort;
    if (!stall_mem) begin
      wb_result_d    = is_load ? dmem_rdata : alu_result;
      wb_rd_d        = rd;
      wb_reg_write_d = reg_write & ~abort & ~drop_mis;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      wb_result_q    <= '0;
      wb_rd_q        <= '0;
      wb_reg_write_q <= 1'b0;
      bus_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      wb_result_q    <= wb_result_d;
      wb_rd_q        <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
      bus_err_q      <= bus_err_d;
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  logic misalign_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= drop_mis;
    end
  end
  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  assign wb_result    = wb_result_q;
  assign wb_rd        = wb_rd_q;
  assign wb_reg_write = wb_reg_write_q;
  assign bus_err      = bus_err_q;

endmodule
